// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART transmit controller with a baud divider, a bit counter, a shift
// register, a parity generator and a registered line driver.
// A word is captured on a valid/accept handshake together with its frame configuration.
// Consecutive frames can run back to back with no idle gap.
//
// Ports:
//   CLK        - system clock, rising edge
//   RST        - asynchronous reset, active-low
//   P_DATA     - parallel data word, sent LSB first
//   Data_Valid - source has a word; held until accept
//   PAR_EN     - insert a parity bit
//   PAR_TYP    - 0 = even, 1 = odd parity
//   STOP2      - two stop bits when set
//   Prescale   - CLK cycles per bit; 0 behaves as 1
//   TX_OUT     - serial line, registered, idle high
//   busy       - high while a frame is on the line
//   accept     - one-cycle pulse when the word and configuration are captured
module uart_tx_frame_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_W-1:0]     P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  accept
);

    localparam int unsigned BitW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] tick_q, tick_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept_q, accept_d;
    logic                  tick_last;
    logic                  capture;

    always_comb begin
        tick_last  = (tick_q == prescale_q - PRESCALE_W'(1));
        capture    = 1'b0;
        state_d    = state_q;
        tick_d     = tick_q;
        prescale_d = prescale_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        accept_d   = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                tick_d  = '0;
                bit_d   = '0;
                capture = Data_Valid;
            end
            StStart: begin
                if (tick_last) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    tick_d  = '0;
                    bit_d   = '0;
                end else begin
                    tick_d = tick_q + PRESCALE_W'(1);
                end
            end
            StData: begin
                if (tick_last) begin
                    tick_d = '0;
                    if (bit_q == BitW'(DATA_W - 1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Bit 0 of the shifted word is the bit now on the line.
                        bit_d   = bit_q + BitW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    tick_d = tick_q + PRESCALE_W'(1);
                end
            end
            StParity: begin
                if (tick_last) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    tick_d  = '0;
                    bit_d   = '0;
                end else begin
                    tick_d = tick_q + PRESCALE_W'(1);
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (tick_last) begin
                    tick_d = '0;
                    if (stop2_q && (bit_q == '0)) begin
                        // bit_q counts stop bits here.
                        bit_d = BitW'(1);
                    end else if (Data_Valid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                    end
                end else begin
                    tick_d = tick_q + PRESCALE_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        if (capture) begin
            shift_d    = P_DATA;
            par_en_d   = PAR_EN;
            par_bit_d  = (^P_DATA) ^ PAR_TYP;
            stop2_d    = STOP2;
            prescale_d = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
            accept_d   = 1'b1;
            busy_d     = 1'b1;
            tx_d       = 1'b0;
            state_d    = StStart;
            tick_d     = '0;
            bit_d      = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            prescale_q <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            accept_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            prescale_q <= prescale_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            accept_q   <= accept_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;
    assign accept = accept_q;

endmodule
